// File: rtl/raster_bbox_scanner.sv
// Bounding-box scanner feeding the barycentric stage: latches a triangle, re-initialises the stage,
// then streams pixel centres with a delay-aligned pixel tag. Optional counters: RASTER_STATS_EN.
module raster_bbox_scanner #(
    parameter int COORD_WIDTH  = 32,
    parameter int FRAC_BITS    = 4,
    parameter int SCREEN_W     = 320,
    parameter int SCREEN_H     = 180,
    parameter int BC_DELAY     = 8,
    parameter int INIT_TIMEOUT = 128
) (
    input  logic                                 clk_in,
    input  logic                                 rst_n_in,
    input  logic                                 tri_valid_in,
    output logic                                 tri_ready_out,
    input  logic [2:0][COORD_WIDTH/2-1:0]        tri_a_in,
    input  logic [2:0][COORD_WIDTH/2-1:0]        tri_b_in,
    input  logic [2:0][COORD_WIDTH/2-1:0]        tri_c_in,
    output logic                                 bc_rst_out,
    output logic                                 bc_init_out,
    output logic [2:0][COORD_WIDTH/2-1:0]        bc_a_out,
    output logic [2:0][COORD_WIDTH/2-1:0]        bc_b_out,
    output logic [2:0][COORD_WIDTH/2-1:0]        bc_c_out,
    input  logic                                 bc_init_done_in,
    input  logic                                 bc_done_in,
    output logic [2:0][COORD_WIDTH/2-1:0]        bc_p_out,
    output logic                                 bc_valid_out,
    output logic [$clog2(SCREEN_W)-1:0]          tag_x_out,
    output logic [$clog2(SCREEN_H)-1:0]          tag_y_out,
    output logic                                 tag_valid_out,
    output logic                                 tag_last_out,
    output logic                                 busy_out,
    output logic                                 done_out,
    output logic                                 degenerate_out,
    output logic [31:0]                          stat_issued_out,
    output logic [31:0]                          stat_tris_out
);

    localparam int CW  = COORD_WIDTH / 2;
    localparam int TXW = $clog2(SCREEN_W);
    localparam int TYW = $clog2(SCREEN_H);
    localparam int TW  = $clog2(INIT_TIMEOUT + 1);
    localparam int DW  = $clog2(BC_DELAY + 1);

    localparam logic signed [CW-1:0] XLIM = CW'(SCREEN_W - 1);
    localparam logic signed [CW-1:0] YLIM = CW'(SCREEN_H - 1);
    localparam logic        [CW-1:0] HALF = CW'(1) << (FRAC_BITS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_INIT   = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_SCAN   = 3'd4;
    localparam logic [2:0] S_DRAIN  = 3'd5;
    localparam logic [2:0] S_FINISH = 3'd6;

    typedef struct packed {
        logic           valid;
        logic [TXW-1:0] x;
        logic [TYW-1:0] y;
        logic           last;
    } tag_t;

    function automatic logic signed [CW-1:0] min3(input logic signed [CW-1:0] a,
                                                  input logic signed [CW-1:0] b,
                                                  input logic signed [CW-1:0] c);
        logic signed [CW-1:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic signed [CW-1:0] max3(input logic signed [CW-1:0] a,
                                                  input logic signed [CW-1:0] b,
                                                  input logic signed [CW-1:0] c);
        logic signed [CW-1:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    logic [2:0]           state_q, state_d;
    logic signed [CW-1:0] xmin_q, xmin_d, xmax_q, xmax_d;
    logic signed [CW-1:0] ymin_q, ymin_d, ymax_q, ymax_d;
    logic signed [CW-1:0] x_q, x_d, y_q, y_d;
    logic                 degen_q, degen_d;
    logic [TW-1:0]        tmo_q, tmo_d;
    logic [DW-1:0]        drain_q, drain_d;
    logic                 bc_rst_q;
    logic [1:0][CW-1:0]   va_q, va_d, vb_q, vb_d, vc_q, vc_d;
    tag_t                 pipe_q [BC_DELAY];
    tag_t                 tag_in;

    logic signed [CW-1:0] raw_xmin, raw_xmax, raw_ymin, raw_ymax;
    logic signed [CW-1:0] cl_xmin, cl_xmax, cl_ymin, cl_ymax;
    logic                 bbox_empty, scanning, scan_last;
    logic                 unused_z;

    assign unused_z = ^{tri_a_in[2], tri_b_in[2], tri_c_in[2]};

    // Pixel bbox from the raw vertices, intersected with the screen so off-screen triangles come out empty.
    assign raw_xmin = min3($signed(tri_a_in[0]), $signed(tri_b_in[0]), $signed(tri_c_in[0])) >>> FRAC_BITS;
    assign raw_xmax = max3($signed(tri_a_in[0]), $signed(tri_b_in[0]), $signed(tri_c_in[0])) >>> FRAC_BITS;
    assign raw_ymin = min3($signed(tri_a_in[1]), $signed(tri_b_in[1]), $signed(tri_c_in[1])) >>> FRAC_BITS;
    assign raw_ymax = max3($signed(tri_a_in[1]), $signed(tri_b_in[1]), $signed(tri_c_in[1])) >>> FRAC_BITS;
    assign cl_xmin  = raw_xmin[CW-1] ? '0 : raw_xmin;
    assign cl_ymin  = raw_ymin[CW-1] ? '0 : raw_ymin;
    assign cl_xmax  = (raw_xmax > XLIM) ? XLIM : raw_xmax;
    assign cl_ymax  = (raw_ymax > YLIM) ? YLIM : raw_ymax;
    assign bbox_empty = (cl_xmin > cl_xmax) || (cl_ymin > cl_ymax);

    assign scanning  = (state_q == S_SCAN);
    assign scan_last = scanning && (x_q == xmax_q) && (y_q == ymax_q);

    always_comb begin
        state_d = state_q;
        xmin_d  = xmin_q;
        xmax_d  = xmax_q;
        ymin_d  = ymin_q;
        ymax_d  = ymax_q;
        x_d     = x_q;
        y_d     = y_q;
        degen_d = degen_q;
        tmo_d   = tmo_q;
        drain_d = drain_q;
        va_d    = va_q;
        vb_d    = vb_q;
        vc_d    = vc_q;
        case (state_q)
            S_IDLE: begin
                if (tri_valid_in) begin
                    va_d    = tri_a_in[1:0];
                    vb_d    = tri_b_in[1:0];
                    vc_d    = tri_c_in[1:0];
                    xmin_d  = cl_xmin;
                    xmax_d  = cl_xmax;
                    ymin_d  = cl_ymin;
                    ymax_d  = cl_ymax;
                    degen_d = bbox_empty;
                    state_d = bbox_empty ? S_FINISH : S_CLEAR;
                end
            end
            S_CLEAR: state_d = S_INIT;
            S_INIT: begin
                tmo_d   = TW'(INIT_TIMEOUT);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bc_init_done_in) begin
                    x_d     = xmin_q;
                    y_d     = ymin_q;
                    state_d = S_SCAN;
                end else if (bc_done_in || tmo_q <= TW'(1)) begin
                    degen_d = 1'b1;
                    state_d = S_FINISH;
                end else begin
                    tmo_d = tmo_q - TW'(1);
                end
            end
            S_SCAN: begin
                if (x_q == xmax_q) begin
                    x_d = xmin_q;
                    if (y_q == ymax_q) begin
                        drain_d = DW'(BC_DELAY - 1);
                        state_d = (BC_DELAY > 1) ? S_DRAIN : S_FINISH;
                    end else begin
                        y_d = y_q + CW'(1);
                    end
                end else begin
                    x_d = x_q + CW'(1);
                end
            end
            // Drain ends so that done_out lands on the same cycle as the last tag.
            S_DRAIN: begin
                if (drain_q <= DW'(1)) begin
                    state_d = S_FINISH;
                end else begin
                    drain_d = drain_q - DW'(1);
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q  <= S_IDLE;
            xmin_q   <= '0;
            xmax_q   <= '0;
            ymin_q   <= '0;
            ymax_q   <= '0;
            x_q      <= '0;
            y_q      <= '0;
            degen_q  <= 1'b0;
            tmo_q    <= '0;
            drain_q  <= '0;
            va_q     <= '0;
            vb_q     <= '0;
            vc_q     <= '0;
            bc_rst_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            xmin_q   <= xmin_d;
            xmax_q   <= xmax_d;
            ymin_q   <= ymin_d;
            ymax_q   <= ymax_d;
            x_q      <= x_d;
            y_q      <= y_d;
            degen_q  <= degen_d;
            tmo_q    <= tmo_d;
            drain_q  <= drain_d;
            va_q     <= va_d;
            vb_q     <= vb_d;
            vc_q     <= vc_d;
            bc_rst_q <= (state_d == S_CLEAR);
        end
    end

    always_comb begin
        tag_in = '0;
        if (scanning) begin
            tag_in.valid = 1'b1;
            tag_in.x     = x_q[TXW-1:0];
            tag_in.y     = y_q[TYW-1:0];
            tag_in.last  = scan_last;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < BC_DELAY; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= tag_in;
            for (int i = 1; i < BC_DELAY; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    always_comb begin
        bc_p_out = '0;
        if (scanning) begin
            bc_p_out[0] = (x_q <<< FRAC_BITS) | HALF;
            bc_p_out[1] = (y_q <<< FRAC_BITS) | HALF;
        end
    end

    assign tri_ready_out  = rst_n_in && (state_q == S_IDLE);
    assign bc_rst_out     = bc_rst_q;
    assign bc_init_out    = (state_q == S_INIT);
    assign bc_valid_out   = scanning;
    assign bc_a_out       = {CW'(0), va_q};
    assign bc_b_out       = {CW'(0), vb_q};
    assign bc_c_out       = {CW'(0), vc_q};
    assign tag_valid_out  = pipe_q[BC_DELAY-1].valid;
    assign tag_x_out      = pipe_q[BC_DELAY-1].x;
    assign tag_y_out      = pipe_q[BC_DELAY-1].y;
    assign tag_last_out   = pipe_q[BC_DELAY-1].last;
    assign busy_out       = (state_q != S_IDLE);
    assign done_out       = (state_q == S_FINISH);
    assign degenerate_out = done_out && degen_q;

`ifdef RASTER_STATS_EN
    logic [31:0] issued_q, tris_q;

    // Saturating counters, cleared only by reset.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            issued_q <= '0;
            tris_q   <= '0;
        end else begin
            if (bc_valid_out && issued_q != '1) issued_q <= issued_q + 32'd1;
            if (done_out && tris_q != '1)       tris_q   <= tris_q + 32'd1;
        end
    end

    assign stat_issued_out = issued_q;
    assign stat_tris_out   = tris_q;
`else
    assign stat_issued_out = '0;
    assign stat_tris_out   = '0;
`endif

endmodule

// File: tb/tb_raster_bbox_scanner.sv
// Scoreboard bench for raster_bbox_scanner: directed triangles push expected pixels/completions,
// negedge monitors pop and compare; a small barycentric model answers init pulses.
module tb_raster_bbox_scanner;

    typedef struct {
        int x;
        int y;
        bit last;
    } pix_t;

    logic              clk_in = 1'b0;
    logic              rst_n_in = 1'b0;
    logic              tri_valid_in = 1'b0;
    logic              tri_ready_out;
    logic [2:0][15:0]  tri_a_in = '0, tri_b_in = '0, tri_c_in = '0;
    logic              bc_rst_out, bc_init_out;
    logic [2:0][15:0]  bc_a_out, bc_b_out, bc_c_out, bc_p_out;
    logic              bc_init_done_in = 1'b0, bc_done_in = 1'b0;
    logic              bc_valid_out;
    logic [8:0]        tag_x_out;
    logic [7:0]        tag_y_out;
    logic              tag_valid_out, tag_last_out, busy_out, done_out, degenerate_out;
    logic [31:0]       stat_issued_out, stat_tris_out;

    pix_t expIss[$];
    pix_t expTag[$];
    int   expDone[$];
    int   issueCyc[$];
    int   cycle = 0, checks = 0, errors = 0;
    int   doneCnt = 0, initCnt = 0, issueCnt = 0;
    int   lastIssueCycle = 0, lastDoneCycle = 0, acceptCycle = 0;
    int   bcMode = 0, initPend = 0;

    raster_bbox_scanner dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .tri_valid_in(tri_valid_in), .tri_ready_out(tri_ready_out),
        .tri_a_in(tri_a_in), .tri_b_in(tri_b_in), .tri_c_in(tri_c_in),
        .bc_rst_out(bc_rst_out), .bc_init_out(bc_init_out),
        .bc_a_out(bc_a_out), .bc_b_out(bc_b_out), .bc_c_out(bc_c_out),
        .bc_init_done_in(bc_init_done_in), .bc_done_in(bc_done_in),
        .bc_p_out(bc_p_out), .bc_valid_out(bc_valid_out),
        .tag_x_out(tag_x_out), .tag_y_out(tag_y_out),
        .tag_valid_out(tag_valid_out), .tag_last_out(tag_last_out),
        .busy_out(busy_out), .done_out(done_out), .degenerate_out(degenerate_out),
        .stat_issued_out(stat_issued_out), .stat_tris_out(stat_tris_out)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cycle++;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Barycentric model: answers each init pulse three cycles later according to bcMode.
    always @(negedge clk_in) begin
        bc_init_done_in = 1'b0;
        bc_done_in      = 1'b0;
        if (!rst_n_in) begin
            initPend = 0;
        end else begin
            if (initPend > 0) begin
                initPend--;
                if (initPend == 0) begin
                    if (bcMode == 0) bc_init_done_in = 1'b1;
                    else if (bcMode == 1) bc_done_in = 1'b1;
                end
            end
            if (bc_init_out) initPend = 3;
        end
    end

    always @(negedge clk_in) begin : monitor
        pix_t e;
        int   c, d;
        if (rst_n_in) begin
            if (bc_init_out) initCnt++;
            if (bc_valid_out) begin
                issueCnt++;
                lastIssueCycle = cycle;
                if (expIss.size() == 0) begin
                    checkOutput("issue_unexpected", 1, 0);
                end else begin
                    e = expIss.pop_front();
                    checkOutput("issue_point", bc_p_out, {16'd0, 16'(e.y * 16 + 8), 16'(e.x * 16 + 8)});
                    issueCyc.push_back(cycle);
                end
            end
            if (tag_valid_out) begin
                if (expTag.size() == 0) begin
                    checkOutput("tag_unexpected", 1, 0);
                end else begin
                    e = expTag.pop_front();
                    checkOutput("tag_xy_last", {tag_x_out, tag_y_out, tag_last_out}, {9'(e.x), 8'(e.y), e.last});
                    if (issueCyc.size() > 0) begin
                        c = issueCyc.pop_front();
                        checkOutput("tag_lag", cycle - c, 8);
                    end
                end
            end
            if (done_out) begin
                doneCnt++;
                lastDoneCycle = cycle;
                if (expDone.size() == 0) begin
                    checkOutput("done_unexpected", 1, 0);
                end else begin
                    d = expDone.pop_front();
                    checkOutput("done_degenerate", degenerate_out, d);
                    if (d == 0) checkOutput("done_timing", cycle - lastIssueCycle, 8);
                end
            end
        end
    end

    task automatic expectScan(input int xmin, input int xmax, input int ymin, input int ymax);
        pix_t p;
        for (int y = ymin; y <= ymax; y++) begin
            for (int x = xmin; x <= xmax; x++) begin
                p.x = x;
                p.y = y;
                p.last = (x == xmax) && (y == ymax);
                expIss.push_back(p);
                expTag.push_back(p);
            end
        end
        expDone.push_back(0);
    endtask

    task automatic applyStimulus(input int ax, input int ay, input int az, input int bx, input int by,
                                 input int bz, input int cx, input int cy, input int cz);
        int n = 0;
        while (!tri_ready_out && n < 400) begin
            @(negedge clk_in);
            n++;
        end
        checkOutput("ready_before_accept", tri_ready_out, 1);
        tri_a_in = {16'(az), 16'(ay), 16'(ax)};
        tri_b_in = {16'(bz), 16'(by), 16'(bx)};
        tri_c_in = {16'(cz), 16'(cy), 16'(cx)};
        tri_valid_in = 1'b1;
        @(negedge clk_in);
        tri_valid_in = 1'b0;
        acceptCycle = cycle;
    endtask

    task automatic waitDone(input int d0, input int limit);
        int n = 0;
        while (doneCnt == d0 && n < limit) begin
            @(negedge clk_in);
            n++;
        end
        checkOutput("done_seen", doneCnt != d0, 1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int d0, ic0, is0, n;
        repeat (3) @(negedge clk_in);
        checkOutput("rst_ready", tri_ready_out, 0);
        checkOutput("rst_bc_rst", bc_rst_out, 1);
        checkOutput("rst_outputs", {bc_valid_out, bc_init_out, tag_valid_out, done_out, busy_out}, 0);
        checkOutput("rst_stats", {stat_issued_out, stat_tris_out}, 0);
        rst_n_in = 1'b1;
        @(negedge clk_in);
        checkOutput("post_rst_ready", tri_ready_out, 1);
        checkOutput("post_rst_bc_rst", bc_rst_out, 0);

        // 12-pixel triangle, with offers ignored while busy
        d0 = doneCnt;
        expectScan(0, 3, 0, 2);
        applyStimulus(0, 0, 5, 48, 0, 0, 0, 32, 0);
        checkOutput("clear_cycle", {bc_rst_out, bc_init_out, busy_out, tri_ready_out}, 4'b1010);
        checkOutput("bc_a_latched", bc_a_out, 48'd0);
        checkOutput("bc_b_latched", bc_b_out, {16'd0, 16'd0, 16'd48});
        checkOutput("bc_c_latched", bc_c_out, {16'd0, 16'd32, 16'd0});
        @(negedge clk_in);
        checkOutput("init_cycle", {bc_rst_out, bc_init_out}, 2'b01);
        tri_a_in = {16'd0, 16'd100, 16'd100};
        tri_valid_in = 1'b1;
        repeat (4) @(negedge clk_in);
        tri_valid_in = 1'b0;
        waitDone(d0, 200);
        checkOutput("bc_a_held", bc_a_out, 48'd0);

        // Clamped row: x -5..400 px -> 0..319, two rows
        d0 = doneCnt;
        expectScan(0, 319, 0, 1);
        applyStimulus(-80, 0, 0, 6400, 0, 0, 0, 16, 0);
        waitDone(d0, 2000);

        // Entirely left of the screen
        d0 = doneCnt; ic0 = initCnt; is0 = issueCnt;
        expDone.push_back(1);
        applyStimulus(-80, 0, 0, -32, 16, 0, -48, 16, 0);
        waitDone(d0, 10);
        checkOutput("degen_latency_le3", (lastDoneCycle - acceptCycle) <= 3, 1);
        repeat (2) @(negedge clk_in);
        checkOutput("degen_no_init", initCnt - ic0, 0);
        checkOutput("degen_no_issue", issueCnt - is0, 0);

        // Barycentric stage reports an error instead of init_done
        bcMode = 1;
        d0 = doneCnt; ic0 = initCnt; is0 = issueCnt;
        expDone.push_back(1);
        applyStimulus(0, 0, 0, 48, 0, 0, 0, 32, 0);
        waitDone(d0, 100);
        checkOutput("bcerr_init_once", initCnt - ic0, 1);
        checkOutput("bcerr_no_issue", issueCnt - is0, 0);

        // init_done never arrives
        bcMode = 2;
        d0 = doneCnt; is0 = issueCnt;
        expDone.push_back(1);
        applyStimulus(0, 0, 0, 48, 0, 0, 0, 32, 0);
        waitDone(d0, 300);
        checkOutput("timeout_window", (lastDoneCycle - acceptCycle) >= 128 && (lastDoneCycle - acceptCycle) <= 133, 1);
        checkOutput("timeout_no_issue", issueCnt - is0, 0);
        bcMode = 0;

        // Reset dropped mid-scan
        is0 = issueCnt;
        expectScan(0, 3, 0, 2);
        applyStimulus(0, 0, 0, 48, 0, 0, 0, 32, 0);
        n = 0;
        while (issueCnt - is0 < 5 && n < 100) begin
            @(negedge clk_in);
            n++;
        end
        checkOutput("scan_started", issueCnt - is0 >= 5, 1);
        @(posedge clk_in);
        #2;
        rst_n_in = 1'b0;
        expIss.delete();
        expTag.delete();
        expDone.delete();
        issueCyc.delete();
        #1;
        checkOutput("midrst_outputs", {bc_valid_out, tag_valid_out, bc_rst_out, tri_ready_out, done_out}, 5'b00100);
        repeat (2) @(negedge clk_in);
        rst_n_in = 1'b1;
        @(negedge clk_in);
        checkOutput("midrst_ready", tri_ready_out, 1);

        d0 = doneCnt;
        expectScan(0, 3, 0, 2);
        applyStimulus(0, 0, 0, 48, 0, 0, 0, 32, 0);
        waitDone(d0, 200);

        // Single pixel at (5,7)
        d0 = doneCnt;
        expectScan(5, 5, 7, 7);
        applyStimulus(83, 112, 0, 89, 114, 0, 80, 127, 0);
        waitDone(d0, 100);
        repeat (2) @(negedge clk_in);

`ifdef RASTER_STATS_EN
        checkOutput("stat_issued", stat_issued_out, 13);
        checkOutput("stat_tris", stat_tris_out, 2);
`else
        checkOutput("stat_issued", stat_issued_out, 0);
        checkOutput("stat_tris", stat_tris_out, 0);
`endif
        checkOutput("queues_drained", expIss.size() + expTag.size() + expDone.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/raster_bbox_scanner.md
Name: raster_bbox_scanner

Overview:
- Upstream feeder for the barycentric coordinate stage.
- Accepts one screen-space triangle and computes its clamped integer bounding box.
- Re-initialises the barycentric stage for that triangle: one reset pulse, one init pulse, then waits for init-done.
- Streams one pixel-centre point per cycle into it, with a pixel-coordinate tag delayed to line up with the barycentric result.

Parameters:
- COORD_WIDTH, 32, barycentric stage width; vertex/point components are COORD_WIDTH/2 signed fixed-point.
- FRAC_BITS, 4, fractional bits in vertex/point components.
- SCREEN_W, 320, screen width in pixels.
- SCREEN_H, 180, screen height in pixels.
- BC_DELAY, 8, cycles from point issue to barycentric result.
- INIT_TIMEOUT, 128, maximum cycles to wait for barycentric init.

Ports:
- clk_in  in  1  clock
- rst_n_in  in  1  asynchronous active-low reset
- tri_valid_in  in  1  triangle offered
- tri_ready_out  out  1  high only in IDLE; accept = valid&&ready
- tri_a_in, tri_b_in, tri_c_in  in  3x(COORD_WIDTH/2) each  signed vertices, [0]=x, [1]=y, [2]=z
- bc_rst_out  out  1  active-high synchronous reset to barycentric stage
- bc_init_out  out  1  barycentric init pulse
- bc_a_out, bc_b_out, bc_c_out  out  3x(COORD_WIDTH/2) each  latched vertices, z forced to 0
- bc_init_done_in  in  1  barycentric init_done
- bc_done_in  in  1  barycentric done (division error)
- bc_p_out  out  3x(COORD_WIDTH/2)  pixel-centre point, z=0
- bc_valid_out  out  1  drives barycentric valid_in
- tag_x_out  out  $clog2(SCREEN_W)  pixel x aligned to barycentric output
- tag_y_out  out  $clog2(SCREEN_H)  pixel y aligned to barycentric output
- tag_valid_out  out  1  tag is live
- tag_last_out  out  1  tag is last pixel of triangle
- busy_out  out  1  not IDLE
- done_out  out  1  one-cycle pulse at triangle completion
- degenerate_out  out  1  qualifies done_out: triangle produced no pixels
- stat_issued_out  out  32  see Optional Feature
- stat_tris_out  out  32  see Optional Feature

Behaviour:
- Reset (asynchronous, any state): state=IDLE; tri_ready_out=0 during reset, 1 after; bc_rst_out=1; all other outputs 0; counters 0.
- IDLE:
  - bc_rst_out=0.
  - On accept, latch vertices.
  - bbox: xmin=floor(min x)>>FRAC_BITS, xmax=floor(max x)>>FRAC_BITS, likewise y, arithmetic shift.
  - Clamp bbox to [0,SCREEN_W-1] and [0,SCREEN_H-1].
  - If xmin>xmax or ymin>ymax after clamp, go to FINISH with degenerate set; otherwise go to CLEAR.
- CLEAR: bc_rst_out=1 for exactly 1 cycle -> INIT.
- INIT: bc_init_out=1 for exactly 1 cycle; load timeout counter -> WAIT_INIT.
- WAIT_INIT:
  - bc_init_done_in=1 -> SCAN with x=xmin, y=ymin.
  - bc_done_in=1 or timeout expiry -> FINISH, degenerate=1.
  - init_done takes priority if both rise in the same cycle.
- SCAN:
  - Each cycle: bc_valid_out=1; bc_p_out x=(x<<FRAC_BITS)|(1<<(FRAC_BITS-1)), y likewise, z=0.
  - x increments; at x==xmax, x wraps to xmin and y increments.
  - The cycle with x==xmax and y==ymax is the last -> DRAIN.
  - No backpressure; 1 pixel/clk; bbox area N takes exactly N cycles.
- DRAIN: wait BC_DELAY cycles -> FINISH.
- Tag pipe: shift register BC_DELAY deep carrying {valid,x,y,last}.
  - Loaded from the SCAN outputs; shifts every cycle regardless of state.
  - tag_* equals values issued exactly BC_DELAY cycles earlier.
- FINISH:
  - done_out=1 for 1 cycle; degenerate_out=degenerate flag (0 on normal completion).
  - bc_rst_out stays 0.
  - -> IDLE; tri_ready_out rises the next cycle.
- bc_a/b/c_out: held stable from accept until next accept; z components forced to 0.
- tri_valid_in while busy is ignored, not queued.
- Arithmetic: bbox and counters in signed COORD_WIDTH/2; negative coordinates clamp to 0.

Optional Feature:
- Macro RASTER_STATS_EN.
- Defined:
  - stat_issued_out counts cycles with bc_valid_out=1.
  - stat_tris_out counts done_out pulses.
  - Both saturate at 2^32-1 and clear only on reset.
- Undefined: both ports tied to 0; no counter logic is built.

Test Plan:
- Triangle (0,0),(3<<4,0),(0,2<<4), FRAC_BITS=4 -> 1 CLEAR cycle, 1 INIT cycle; after init_done, 12 consecutive bc_valid_out cycles, raster order (0,0)..(3,2). First bc_p_out x=8, y=8. tag_valid_out lags by exactly 8 cycles; tag_last_out on (3,2); done_out 8 cycles after last issue, degenerate_out=0.
- Vertices spanning x=-5..400 px -> bbox x clamped to 0..319, row wrap 319->0 with y+1.
- Triangle fully at x<0 -> no bc_init_out, no bc_valid_out; done_out with degenerate_out=1 within 3 cycles of accept.
- Model asserts bc_done_in instead of init_done -> FINISH, degenerate_out=1, no pixels. Init_done never asserted -> same result after 128 cycles.
- rst_n_in dropped mid-SCAN -> immediately bc_valid_out=0, tag_valid_out=0, bc_rst_out=1. After release, tri_ready_out=1; a fresh triangle scans correctly.
- With RASTER_STATS_EN, two triangles of 12 and 1 pixels -> stat_issued_out=13, stat_tris_out=2. Without the macro, both read 0.
